// File: rtl/ifetch_unit_if.sv
// Fetch-stage bus: PC input, instruction-memory read port and decode handshake.
// master = ifetch_unit side; slave = PC block / memory / decode side.
// Ports: pc, redirect, imem_en/imem_addr/imem_rdata, instr/instr_pc/instr_valid/instr_ready,
//        fetch_stall, misaligned.
interface ifetch_unit_if #(
  parameter int ADDR_W = 14
);
  logic [31:0]       pc;
  logic              redirect;
  logic              imem_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic [31:0]       instr;
  logic [31:0]       instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              fetch_stall;
  logic              misaligned;

  modport master (
    input  pc, redirect, imem_rdata, instr_ready,
    output imem_en, imem_addr, instr, instr_pc, instr_valid, fetch_stall, misaligned
  );

  modport slave (
    output pc, redirect, imem_rdata, instr_ready,
    input  imem_en, imem_addr, instr, instr_pc, instr_valid, fetch_stall, misaligned
  );
endinterface

// File: rtl/ifetch_unit.sv
// Purpose: turn the PC into a synchronous imem read and queue returned words (with PCs) for decode.
// Latency: issue in cycle N, word pushed at end of N+1, instr_valid in N+2; 1 instr/cycle sustained.
// Backpressure: fetch_stall rises when FIFO + in-flight would exceed DEPTH; releases combinationally on instr_ready.
// Ports: clock, reset (sync, active-high); bus (ifetch_unit_if.master):
//   in  pc, redirect, imem_rdata, instr_ready
//   out imem_en, imem_addr, instr, instr_pc, instr_valid, fetch_stall, misaligned
module ifetch_unit #(
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 2
) (
  input  logic          clock,
  input  logic          reset,
  ifetch_unit_if.master bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  // FIFO storage; DEPTH is a power of two so the pointers wrap naturally.
  logic [31:0]   r_mem_instr [DEPTH];
  logic [31:0]   r_mem_pc    [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  // One read may be outstanding; its data shows up on imem_rdata next cycle.
  logic          r_infl;
  logic [31:0]   r_infl_pc;
  logic          r_mis;

  logic          w_valid;
  logic          w_pop;
  logic [CW:0]   w_occ;
  logic          w_gate;
  logic          w_issue;
  logic          w_mis_set;

  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid & bus.instr_ready;

  // Occupancy after this cycle's pop, counting the response still to arrive.
  // A pop implies count >= 1, so this never underflows.
  assign w_occ = {1'b0, r_count} + {{CW{1'b0}}, r_infl} - {{CW{1'b0}}, w_pop};

  // Everything except alignment: an unaligned PC that would otherwise issue
  // is what raises the sticky error.
  assign w_gate    = !reset & !bus.redirect & !r_mis & (w_occ < (CW+1)'(DEPTH));
  assign w_issue   = w_gate & (bus.pc[1:0] == 2'b00);
  assign w_mis_set = w_gate & (bus.pc[1:0] != 2'b00);

  assign bus.imem_en     = w_issue;
  assign bus.imem_addr   = bus.pc[ADDR_W+1:2];
  assign bus.fetch_stall = !w_issue;
  assign bus.instr       = r_mem_instr[r_rd_ptr];
  assign bus.instr_pc    = r_mem_pc[r_rd_ptr];
  assign bus.instr_valid = w_valid;
  assign bus.misaligned  = r_mis;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_count   <= '0;
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_infl    <= 1'b0;
      r_infl_pc <= '0;
      r_mis     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_instr[i] <= '0;
        r_mem_pc[i]    <= '0;
      end
    end else begin
      r_infl <= w_issue;
      if (w_issue) begin
        r_infl_pc <= bus.pc;
      end
      if (w_mis_set) begin
        r_mis <= 1'b1;
      end

      if (bus.redirect) begin
        // Wrong-path flush: drop queued words and the response arriving now.
        r_count  <= '0;
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (r_infl) begin
          r_mem_instr[r_wr_ptr] <= bus.imem_rdata;
          r_mem_pc[r_wr_ptr]    <= r_infl_pc;
          r_wr_ptr              <= r_wr_ptr + PW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PW'(1);
        end
        case ({r_infl, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch stage that sits directly downstream of the PC register. It converts the current PC into a synchronous instruction-memory read and buffers the returned words in a small FIFO together with their PCs. It then presents them to decode with a valid/ready handshake. It back-pressures the PC through `fetch_stall` and discards wrong-path fetches when a taken branch redirects the PC.

## Interface
- `ADDR_W`, 14: instruction-memory word-address width; `imem_addr = pc[ADDR_W+1:2]`.
- `DEPTH`, 2: instruction FIFO entries (power of two, ≥2).
- `clock`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `pc`  in  32  current PC from the PC block.
- `redirect`  in  1  taken branch this cycle (Branch & Zero); flushes fetch state.
- `imem_en`  out  1  read strobe to instruction memory.
- `imem_addr`  out  ADDR_W  word address of the read.
- `imem_rdata`  in  32  read data, valid exactly 1 cycle after `imem_en`.
- `instr`  out  32  FIFO head instruction.
- `instr_pc`  out  32  PC of `instr`.
- `instr_valid`  out  1  FIFO non-empty.
- `instr_ready`  in  1  decode accepts head this cycle.
- `fetch_stall`  out  1  PC must hold its value this cycle.
- `misaligned`  out  1  sticky fetch-alignment error.

## Operation
- State: FIFO (`instr`, `instr_pc`) of DEPTH entries, `count` (0..DEPTH), in-flight flag `infl`, in-flight PC `infl_pc`, `misaligned` flag.
- `pop = instr_valid & instr_ready`.
- Issue condition: `issue = !reset & !redirect & !misaligned & pc[1:0]==0 & (count + infl - pop) < DEPTH`.
- `imem_en = issue`. `fetch_stall = !issue`. Both are combinational; there is a path from `instr_ready` to `fetch_stall`.
- On issue: at the clock edge, set `infl` to 1 and latch `pc` into `infl_pc`. Without issue, `infl` is cleared.
- Response: when `infl` is 1, `imem_rdata` and `infl_pc` are pushed into the FIFO at that cycle's edge. The push never overflows, because the issue condition guarantees space.
- Push and pop in the same cycle leave `count` unchanged.
- Redirect: at the edge, `count` goes to 0 and `infl` goes to 0. This also kills any response arriving in that cycle. Redirect overrides a simultaneous push or pop. No issue occurs in the redirect cycle, because `pc` still holds the stale sequential address. The branch target is issued the following cycle.
- Misalignment: if `pc[1:0]!=0` while all other issue conditions hold, `misaligned` is set. It stays set until reset, and fetch remains stalled. Entries already in the FIFO still drain normally.
- Reset (synchronous, any cycle, including mid-operation) clears all of the following:
  - `count` to 0
  - `infl` to 0
  - `misaligned` to 0
  - FIFO storage to 0

## Timing
- Reset values: `instr`=0, `instr_pc`=0, `instr_valid`=0, `misaligned`=0. While `reset` is high, `imem_en`=0 and `fetch_stall`=1.
- Latency: issue in cycle N, data on `imem_rdata` in N+1, pushed at the end of N+1, `instr_valid` high in N+2.
- First cycle after reset deassert: issues `pc`, so the first `instr_valid` appears 2 cycles after deassert.
- Throughput: with `instr_ready` held at 1, one instruction per cycle. Steady state has `count`=1 and `infl`=1.
- Backpressure: with `instr_ready`=0 and DEPTH=2, at most 2 fetches are outstanding (FIFO plus in-flight), after which `fetch_stall` is 1. Stall releases in the same cycle `instr_ready` rises.
- Redirect penalty: one bubble cycle with no issue. The target instruction's `instr_valid` rises 3 cycles after the redirect cycle.
- Head outputs are stable while `instr_valid & !instr_ready`.

## Test plan
- Reset then stream: memory word k = `32'hA000_0000+k`, pc increments by 4 whenever `fetch_stall`=0, `instr_ready`=1. Required: `instr_valid` first high 2 cycles after reset; `instr`=A0000000, A0000001, … on consecutive cycles with `instr_pc`=0, 4, 8.
- Backpressure: hold `instr_ready`=0 for 5 cycles mid-stream. Required: `fetch_stall`=1 after 2 outstanding; `instr`/`instr_pc` stable; no word lost or duplicated after release.
- Redirect with in-flight: assert `redirect` while `count`=1 and `infl`=1, then pc=`32'h40`. Required: `instr_valid`=0 next cycle; no issue in the redirect cycle; `instr_pc`=0x40 valid 3 cycles after redirect.
- Simultaneous redirect + pop + push: required `count`=0 afterwards; the popped word is delivered once; the arriving word is dropped.
- Misaligned: pc=`32'h6`. Required: `misaligned`=1 at the next edge and stays 1; `imem_en`=0 thereafter; buffered entries drain; reset clears the flag.
- Reset mid-stream with FIFO full: required `instr_valid`=0, `misaligned`=0, and `imem_en`=0 while reset is high; clean restart from pc=0.
